// File: rtl/poly_pack_buffer_pkg.sv
// saber_pack_pkg: shared constants, state/mode encodings and width lookups
// for the coefficient-to-word packer.
//   N        coefficients per polynomial
//   WORD_W   packed output word width
//   COEFF_W  widest coefficient accepted on the input bus
package saber_pack_pkg;

    localparam int N       = 256;
    localparam int WORD_W  = 64;
    localparam int COEFF_W = 13;

    typedef enum logic [1:0] {
        MODE_13 = 2'd0,
        MODE_10 = 2'd1,
        MODE_4  = 2'd2,
        MODE_1  = 2'd3
    } pack_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_e;

    // Coefficient width in bits for a mode.
    function automatic logic [3:0] pack_width(input logic [1:0] m);
        logic [3:0] w;
        case (m)
            MODE_13: w = 4'd13;
            MODE_10: w = 4'd10;
            MODE_4:  w = 4'd4;
            MODE_1:  w = 4'd1;
            default: w = 4'd13;
        endcase
        return w;
    endfunction

    // Number of packed words per polynomial: N*W/64.
    function automatic logic [5:0] pack_words(input logic [1:0] m);
        logic [5:0] n;
        case (m)
            MODE_13: n = 6'd52;
            MODE_10: n = 6'd40;
            MODE_4:  n = 6'd16;
            MODE_1:  n = 6'd4;
            default: n = 6'd52;
        endcase
        return n;
    endfunction

    // Mask keeping only the active coefficient bits.
    function automatic logic [COEFF_W-1:0] pack_mask(input logic [1:0] m);
        logic [COEFF_W-1:0] k;
        case (m)
            MODE_13: k = 13'h1FFF;
            MODE_10: k = 13'h03FF;
            MODE_4:  k = 13'h000F;
            MODE_1:  k = 13'h0001;
            default: k = 13'h1FFF;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/poly_pack_buffer_if.sv
// Handshake bundle of the packer.
//   coeff_valid/coeff_ready/coeff_data : coefficient input stream
//   word_valid/word_ready/word_data/word_last : packed word output stream
// master = producer of coefficients / consumer of words (arithmetic side + memory port)
// slave  = the packer itself
interface poly_pack_buffer_if #(
    parameter int WORD_W = 64
);
    logic                                coeff_valid;
    logic                                coeff_ready;
    logic [saber_pack_pkg::COEFF_W-1:0]  coeff_data;
    logic                                word_valid;
    logic                                word_ready;
    logic [WORD_W-1:0]                   word_data;
    logic                                word_last;

    modport master (
        output coeff_valid, coeff_data, word_ready,
        input  coeff_ready, word_valid, word_data, word_last
    );

    modport slave (
        input  coeff_valid, coeff_data, word_ready,
        output coeff_ready, word_valid, word_data, word_last
    );
endinterface

// File: rtl/poly_pack_buffer.sv
// poly_pack_buffer: packs one polynomial of N coefficients (13/10/4/1 bit
// each) into dense little-endian WORD_W-bit words.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  one-cycle pulse: latch mode, clear state, begin a polynomial
//   mode   width select sampled on start
//   bus    slave side of poly_pack_buffer_if (coefficient in, word out)
//   busy   high while a polynomial is being packed
//   done   one-cycle pulse after the last word handshake
module poly_pack_buffer #(
    parameter int N      = saber_pack_pkg::N,
    parameter int WORD_W = saber_pack_pkg::WORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    poly_pack_buffer_if.slave    bus,
    output logic                 busy,
    output logic                 done
);
    import saber_pack_pkg::*;

    localparam int ACC_W = 2 * WORD_W;

    pack_state_e          r_state;
    logic [ACC_W-1:0]     r_acc;
    logic [6:0]           r_fill;
    logic [8:0]           r_ccnt;
    logic [5:0]           r_wcnt;
    logic [1:0]           r_mode;
    logic                 r_busy;
    logic                 r_done;

    logic [3:0]           w_width;
    logic [5:0]           w_words;
    logic [COEFF_W-1:0]   w_mask;
    logic [ACC_W-1:0]     w_coeff_ext;
    logic [ACC_W-1:0]     w_ins;
    logic                 w_coeff_ready;
    logic                 w_word_valid;
    logic                 w_word_last;
    logic                 w_accept;
    logic                 w_emit;

    assign w_width = pack_width(r_mode);
    assign w_words = pack_words(r_mode);
    assign w_mask  = pack_mask(r_mode);

    // Bits of acc at and above fill are always zero, so an OR of the
    // masked, shifted coefficient is the same as a part-select write.
    assign w_coeff_ext = ACC_W'(bus.coeff_data & w_mask);
    assign w_ins       = w_coeff_ext << r_fill;

    // Accept and emit are decoded from fill alone, so they never overlap.
    assign w_coeff_ready = (r_state == ST_RUN) && (r_fill < 7'(WORD_W));
    assign w_word_valid  = ((r_state == ST_RUN) || (r_state == ST_DRAIN))
                           && (r_fill >= 7'(WORD_W));
    assign w_word_last   = w_word_valid && (r_wcnt == (w_words - 6'd1));
    assign w_accept      = bus.coeff_valid && w_coeff_ready;
    assign w_emit        = w_word_valid && bus.word_ready;

    assign bus.coeff_ready = w_coeff_ready;
    assign bus.word_valid  = w_word_valid;
    assign bus.word_last   = w_word_last;
    assign bus.word_data   = r_acc[WORD_W-1:0];
    assign busy            = r_busy;
    assign done            = r_done;

    // Control FSM plus accumulator datapath; start overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_fill  <= 7'd0;
            r_ccnt  <= 9'd0;
            r_wcnt  <= 6'd0;
            r_mode  <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_state <= ST_RUN;
            r_acc   <= '0;
            r_fill  <= 7'd0;
            r_ccnt  <= 9'd0;
            r_wcnt  <= 6'd0;
            r_mode  <= mode;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_acc  <= r_acc | w_ins;
                        r_fill <= r_fill + {3'd0, w_width};
                        r_ccnt <= r_ccnt + 9'd1;
                        if (r_ccnt == 9'(N - 1)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (w_emit) begin
                        r_acc  <= r_acc >> WORD_W;
                        r_fill <= r_fill - 7'(WORD_W);
                        r_wcnt <= r_wcnt + 6'd1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (w_emit) begin
                        r_acc  <= r_acc >> WORD_W;
                        r_fill <= r_fill - 7'(WORD_W);
                        r_wcnt <= r_wcnt + 6'd1;
                        if (w_word_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/poly_pack_buffer.md
# poly_pack_buffer

Coefficient-to-word packer: the write-back counterpart of the shared coefficient buffer. The shared buffer takes 64-bit memory words and shifts out 13-bit coefficients. This block does the reverse. It accepts one polynomial coefficient per handshake at a selectable bit width (13, 10, 4 or 1 bit) and emits densely packed, little-endian 64-bit words for data memory. It sits between the arithmetic units (add_round, Add_m_pack, pol_mul result path) and the memory write port.

## Interface
Parameters
- N, 256, coefficients per polynomial
- WORD_W, 64, output word width

Ports
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: latch mode, clear state, begin a polynomial
- mode  in  2  width select, sampled on start: 0 = 13-bit, 1 = 10-bit, 2 = 4-bit, 3 = 1-bit
- coeff_valid  in  1  coefficient offered
- coeff_ready  out  1  block accepts a coefficient this cycle
- coeff_data  in  13  coefficient; bits at and above the active width are ignored (masked)
- word_valid  out  1  packed word available
- word_ready  in  1  consumer takes the word this cycle
- word_data  out  64  packed word; the first coefficient is at bit 0
- word_last  out  1  qualifies word_valid: final word of the polynomial
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last word handshake

## Operation
- State machine:
  - IDLE → RUN on start.
  - RUN → DRAIN on acceptance of coefficient N-1.
  - DRAIN → DONE on the word handshake with word_last = 1.
  - DONE → IDLE unconditionally. done = 1 only in DONE.
- Storage:
  - 128-bit accumulator acc.
  - 7-bit fill count.
  - 9-bit coefficient counter ccnt.
  - 6-bit word counter wcnt.
  - 2-bit latched mode.
- Width: W = 13/10/4/1 for mode 0/1/2/3.
- Accept: coeff_ready = (state == RUN) && (fill < 64).
  - On coeff_valid && coeff_ready: acc[fill +: W] ← coeff_data[W-1:0], fill ← fill + W, ccnt ← ccnt + 1.
  - Maximum fill is 63 + 13 = 76, so acc never overflows.
- Emit: word_valid = (state ∈ {RUN, DRAIN}) && (fill ≥ 64). word_data = acc[63:0].
  - On word_valid && word_ready: acc ← acc >> 64 (zero-filled), fill ← fill − 64, wcnt ← wcnt + 1.
- Accept and emit are mutually exclusive by construction (fill < 64 vs fill ≥ 64). No simultaneous update path exists.
- Words per polynomial: 52 / 40 / 16 / 4 for W = 13 / 10 / 4 / 1. N·W is an exact multiple of 64, so fill = 0 at DONE and no padding occurs.
- word_last = word_valid && (wcnt == words(mode) − 1).
- start in any state, including mid-polynomial, aborts the current polynomial:
  - clears acc, fill, ccnt and wcnt;
  - latches the new mode;
  - enters RUN.
  - Any partially packed data is discarded.
- start takes priority over the handshakes in the same cycle.
- coeff_valid outside RUN is ignored.

## Timing
- Reset (rst = 1 at a clock edge):
  - state = IDLE;
  - acc, fill, ccnt, wcnt and mode all 0;
  - coeff_ready, word_valid, word_last, busy and done all 0;
  - word_data = 0.
  - Reset mid-operation discards everything and takes effect in the same cycle.
- coeff_ready, word_valid, word_last and word_data are combinational from registers only. There is no combinational path from the valid/ready inputs to the outputs.
- Latency: a word becomes valid the cycle after the accept that brings fill to ≥ 64.
- Throughput at full rate on both sides:
  - 13-bit: 5 coefficients + 1 emit cycle, on average (64 + 13) / 13 cycles per word.
  - 1-bit: 64 accepts + 1 emit.
- Backpressure: while word_valid && !word_ready, word_data and word_last hold stable and coeff_ready = 0.
- done is asserted exactly 1 cycle after the last-word handshake. busy falls in that same cycle as done.

## Structure
- Package saber_pack_pkg holds:
  - mode encodings;
  - the width lookup function W(mode);
  - the word-count lookup words(mode);
  - N and WORD_W.
- No sub-module is needed: a single module with one FSM and a datapath.
- The variable-offset insert is a masked OR into acc, written as a shifted-and-masked coefficient.

## Test plan
- Mode 0, coefficients 0,1,2,…,255, word_ready always 1.
  - First word = 0x0040_0180_0800_2000.
  - 52 words are emitted; word_last is high only on word 52.
  - done pulses once; busy then drops.
- Mode 3, 256 coefficients of value 1 → 4 words of 0xFFFF_FFFF_FFFF_FFFF, the fourth with word_last.
- Mode 2, every coeff_data = 0x1FF5 → masked to 0x5; 16 words of 0x5555_5555_5555_5555.
- Mode 1, word_ready held low for 10 cycles when the first word is valid.
  - word_data is stable throughout and coeff_ready = 0.
  - After release, 40 words are emitted in order with the correct values.
- Abort cases:
  - rst asserted after 100 coefficients → all outputs 0 the next cycle.
  - start (mode 0) after 30 coefficients → fresh packing; the first word again equals the mode-0 first-word value above when fed 0,1,2,….
